color_tracker: RTL and testbench

- Parametrised successor to the single-colour ball detector.
- Classifies each incoming camera pixel against NUM_CH independent colour-dominance rules and accumulates per-channel x/y sums and pixel counts over the active frame.
- At end of frame, a shared iterative divider computes each channel's centroid.
- Drives video_out with camera video overlaid by a "+" marker at each valid centroid. Sits between the de-Bayer output and the VGA generator.

---
 rtl/color_tracker_if.sv | 29 ++
 rtl/color_tracker.sv | 235 +++++++++++++++++++++++
 tb/tb_color_tracker.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/color_tracker_if.sv
// Video-in / centroid-out bundle for color_tracker; master drives camera video and config.
interface color_tracker_if #(
  parameter int NUM_CH = 2
);
  logic [23:0]         video_in;
  logic                h_sync;
  logic                v_sync;
  logic                active_area;
  logic                freeze;
  logic                overlay_en;
  logic [2*NUM_CH-1:0] cfg_primary;
  logic [8*NUM_CH-1:0] cfg_margin;
  logic [23:0]         video_out;
  logic [10*NUM_CH-1:0] centroid_x;
  logic [9*NUM_CH-1:0]  centroid_y;
  logic [NUM_CH-1:0]   centroid_valid;
  logic                frame_done;
  logic                frame_overrun;

  modport master (
    output video_in, h_sync, v_sync, active_area, freeze, overlay_en, cfg_primary, cfg_margin,
    input  video_out, centroid_x, centroid_y, centroid_valid, frame_done, frame_overrun
  );

  modport slave (
    input  video_in, h_sync, v_sync, active_area, freeze, overlay_en, cfg_primary, cfg_margin,
    output video_out, centroid_x, centroid_y, centroid_valid, frame_done, frame_overrun
  );
endinterface

// File: rtl/color_tracker.sv
// Multi-channel colour blob tracker: per-channel centroid via shared serial divider, "+" overlay.
// video_out lags video_in by 1 clock; no backpressure, pixel stream is never stalled.
module color_tracker #(
  parameter int          H_RES      = 640,
  parameter int          V_RES      = 480,
  parameter int          NUM_CH     = 2,
  parameter int          SUM_W      = 28,
  parameter int          CNT_W      = 19,
  parameter int          MIN_PIXELS = 64,
  parameter int          MARK_LEN   = 8,
  parameter logic [23:0] MARK_COLOR = 24'h7F7F7F
) (
  input logic            ball_clock,
  input logic            reset,
  color_tracker_if.slave bus
);
  localparam int XW  = 10;
  localparam int YW  = 9;
  localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int IW  = CHW + 1;
  localparam int BW  = $clog2(SUM_W + 1);

  typedef enum logic [1:0] {S_IDLE, S_DIV, S_UPDATE} state_t;
  state_t state_q, state_d;

  logic hs_q, vs_q;
  logic active_line, frame_end, line_end;
  assign active_line = bus.h_sync & bus.v_sync;
  assign frame_end   = vs_q & ~bus.v_sync;
  assign line_end    = hs_q & ~bus.h_sync;

  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;

  always_comb begin
    x_d = x_q;
    if (!bus.h_sync)                                x_d = '0;
    else if (bus.v_sync && x_q != XW'(H_RES - 1))   x_d = x_q + XW'(1);
    y_d = y_q;
    if (!bus.v_sync)                                y_d = '0;
    else if (line_end && y_q != YW'(V_RES - 1))     y_d = y_q + YW'(1);
  end

  // 9-bit compare keeps component + margin from wrapping.
  function automatic logic dominant(input logic [1:0] prim, input logic [7:0] r, g, b, margin);
    logic [8:0] m;
    m = {1'b0, margin};
    case (prim)
      2'd0:    return ({1'b0, r} > {1'b0, g} + m) && ({1'b0, r} > {1'b0, b} + m);
      2'd1:    return ({1'b0, g} > {1'b0, r} + m) && ({1'b0, g} > {1'b0, b} + m);
      2'd2:    return ({1'b0, b} > {1'b0, r} + m) && ({1'b0, b} > {1'b0, g} + m);
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [SUM_W-1:0] sat_add(input logic [SUM_W-1:0] a, input logic [SUM_W-1:0] b);
    logic [SUM_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[SUM_W] ? '1 : s[SUM_W-1:0];
  endfunction

  logic [NUM_CH-1:0] match;
  logic [SUM_W-1:0]  sx_q[NUM_CH], sx_d[NUM_CH], sy_q[NUM_CH], sy_d[NUM_CH];
  logic [CNT_W-1:0]  cnt_q[NUM_CH], cnt_d[NUM_CH];
  logic [SUM_W-1:0]  hsx_q[NUM_CH], hsy_q[NUM_CH];
  logic [CNT_W-1:0]  hcnt_q[NUM_CH];

  always_comb begin
    for (int k = 0; k < NUM_CH; k++) begin
      match[k] = dominant(bus.cfg_primary[2*k +: 2], bus.video_in[23:16], bus.video_in[15:8],
                          bus.video_in[7:0], bus.cfg_margin[8*k +: 8]);
      sx_d[k]  = sx_q[k];
      sy_d[k]  = sy_q[k];
      cnt_d[k] = cnt_q[k];
      if (frame_end) begin
        sx_d[k]  = '0;
        sy_d[k]  = '0;
        cnt_d[k] = '0;
      end else if (active_line && bus.active_area && match[k]) begin
        sx_d[k]  = sat_add(sx_q[k], SUM_W'(x_q));
        sy_d[k]  = sat_add(sy_q[k], SUM_W'(y_q));
        cnt_d[k] = (cnt_q[k] == '1) ? cnt_q[k] : cnt_q[k] + CNT_W'(1);
      end
    end
  end

  // Restoring divider: bit_q==0 loads the dividend, steps 1..SUM_W each retire one quotient bit.
  logic [IW-1:0]    idx_q;
  logic [BW-1:0]    bit_q;
  logic [SUM_W-1:0] dvd_q, quot, div_num;
  logic [CNT_W-1:0] rem_q, rem_next, div_cnt;
  logic [CNT_W:0]   shifted;
  logic [CHW-1:0]   cur_ch;
  logic             ge, cnt_zero, op_done, last_op;

  assign cur_ch   = idx_q[IW-1:1];
  assign div_cnt  = hcnt_q[cur_ch];
  assign div_num  = idx_q[0] ? hsy_q[cur_ch] : hsx_q[cur_ch];
  assign shifted  = {rem_q, dvd_q[SUM_W-1]};
  assign ge       = shifted >= {1'b0, div_cnt};
  assign rem_next = ge ? CNT_W'(shifted - {1'b0, div_cnt}) : shifted[CNT_W-1:0];
  assign quot     = {dvd_q[SUM_W-2:0], ge};
  assign cnt_zero = (div_cnt == '0);
  assign op_done  = (bit_q == BW'(SUM_W)) || (bit_q == '0 && cnt_zero);
  assign last_op  = (idx_q == IW'(2*NUM_CH - 1));

  logic snap_en, overrun, upd_en;

  always_ff @(posedge ball_clock) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    snap_en = 1'b0;
    overrun = 1'b0;
    upd_en  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (frame_end) begin
          snap_en = 1'b1;
          state_d = S_DIV;
        end
      end
      S_DIV: begin
        overrun = frame_end;
        if (op_done && last_op) state_d = S_UPDATE;
      end
      S_UPDATE: begin
        overrun = frame_end;
        upd_en  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  logic [XW-1:0]        qx_q[NUM_CH];
  logic [YW-1:0]        qy_q[NUM_CH];
  logic [XW*NUM_CH-1:0] cx_q;
  logic [YW*NUM_CH-1:0] cy_q;
  logic [NUM_CH-1:0]    valid_q, hit;
  logic                 frame_done_q, frame_overrun_q, mark;
  logic [23:0]          video_q;

  // Absolute distances avoid wrap-around markers at the image edges.
  function automatic logic on_marker(input logic [XW-1:0] x, input logic [XW-1:0] cx,
                                     input logic [YW-1:0] y, input logic [YW-1:0] cy);
    logic [XW-1:0] dx;
    logic [YW-1:0] dy;
    dx = (x >= cx) ? x - cx : cx - x;
    dy = (y >= cy) ? y - cy : cy - y;
    return ((x == cx) && (dy <= YW'(MARK_LEN))) || ((y == cy) && (dx <= XW'(MARK_LEN)));
  endfunction

  always_comb begin
    for (int k = 0; k < NUM_CH; k++)
      hit[k] = valid_q[k] && on_marker(x_q, cx_q[XW*k +: XW], y_q, cy_q[YW*k +: YW]);
    mark = bus.overlay_en & active_line & (|hit);
  end

  always_ff @(posedge ball_clock) begin
    if (reset) begin
      hs_q <= 1'b0;  vs_q <= 1'b0;
      x_q  <= '0;    y_q  <= '0;
      idx_q <= '0;   bit_q <= '0;
      dvd_q <= '0;   rem_q <= '0;
      cx_q <= '0;    cy_q <= '0;   valid_q <= '0;
      frame_done_q <= 1'b0;  frame_overrun_q <= 1'b0;
      video_q <= '0;
      for (int k = 0; k < NUM_CH; k++) begin
        sx_q[k] <= '0;  sy_q[k] <= '0;  cnt_q[k] <= '0;
        hsx_q[k] <= '0; hsy_q[k] <= '0; hcnt_q[k] <= '0;
        qx_q[k] <= '0;  qy_q[k] <= '0;
      end
    end else begin
      hs_q <= bus.h_sync;
      vs_q <= bus.v_sync;
      x_q  <= x_d;
      y_q  <= y_d;
      for (int k = 0; k < NUM_CH; k++) begin
        sx_q[k]  <= sx_d[k];
        sy_q[k]  <= sy_d[k];
        cnt_q[k] <= cnt_d[k];
      end
      if (snap_en) begin
        for (int k = 0; k < NUM_CH; k++) begin
          hsx_q[k]  <= sx_q[k];
          hsy_q[k]  <= sy_q[k];
          hcnt_q[k] <= cnt_q[k];
        end
        idx_q <= '0;
        bit_q <= '0;
      end else if (state_q == S_DIV) begin
        if (bit_q == '0) begin
          dvd_q <= div_num;
          rem_q <= '0;
        end else begin
          dvd_q <= quot;
          rem_q <= rem_next;
        end
        if (op_done) begin
          if (idx_q[0]) qy_q[cur_ch] <= cnt_zero ? '0 : quot[YW-1:0];
          else          qx_q[cur_ch] <= cnt_zero ? '0 : quot[XW-1:0];
          idx_q <= idx_q + IW'(1);
          bit_q <= '0;
        end else begin
          bit_q <= bit_q + BW'(1);
        end
      end
      if (upd_en && !bus.freeze) begin
        for (int k = 0; k < NUM_CH; k++) begin
          if (hcnt_q[k] >= CNT_W'(MIN_PIXELS)) begin
            cx_q[XW*k +: XW] <= qx_q[k];
            cy_q[YW*k +: YW] <= qy_q[k];
            valid_q[k]       <= 1'b1;
          end else begin
            valid_q[k] <= 1'b0;
          end
        end
      end
      frame_done_q    <= upd_en;
      frame_overrun_q <= overrun;
      video_q         <= mark ? MARK_COLOR : bus.video_in;
    end
  end

  assign bus.video_out      = video_q;
  assign bus.centroid_x     = cx_q;
  assign bus.centroid_y     = cy_q;
  assign bus.centroid_valid = valid_q;
  assign bus.frame_done     = frame_done_q;
  assign bus.frame_overrun  = frame_overrun_q;
endmodule

// File: tb/tb_color_tracker.sv
// Directed bench for color_tracker: per-pixel video scoreboard and per-frame centroid scoreboard.
module tb_color_tracker;
  localparam int H = 16, V = 8, NCH = 2, MINP = 4, ML = 2;

  typedef struct packed {
    logic [1:0]  v;
    logic [19:0] cx;
    logic [17:0] cy;
  } res_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  color_tracker_if #(.NUM_CH(NCH)) bus ();

  color_tracker #(.H_RES(H), .V_RES(V), .NUM_CH(NCH), .MIN_PIXELS(MINP), .MARK_LEN(ML)) dut (
    .ball_clock(clk),
    .reset     (rst),
    .bus       (bus)
  );

  int n_pass = 0, n_total = 0;
  int bx0, bx1, by0, by1, gn;
  bit fz, ovl;
  int prim[2] = '{0, 1};
  int marg[2] = '{16, 16};
  res_t m_state;
  res_t rq[$];
  logic [23:0] vq[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [23:0] pixel(int x, int y);
    if (x >= bx0 && x <= bx1 && y >= by0 && y <= by1) return 24'hFF0000;
    if (y == 0 && x >= 1 && x <= gn) return 24'h00FF00;
    return 24'h000000;
  endfunction

  function automatic bit tb_match(int ch, logic [23:0] p);
    int c[3];
    int pr;
    c[0] = int'(p[23:16]);
    c[1] = int'(p[15:8]);
    c[2] = int'(p[7:0]);
    pr = prim[ch];
    if (pr == 3) return 1'b0;
    for (int j = 0; j < 3; j++)
      if (j != pr && !(c[pr] > c[j] + marg[ch])) return 1'b0;
    return 1'b1;
  endfunction

  function automatic res_t predict();
    res_t r;
    int sx[2], sy[2], n[2];
    r = m_state;
    for (int ch = 0; ch < NCH; ch++) begin
      sx[ch] = 0; sy[ch] = 0; n[ch] = 0;
    end
    for (int y = 0; y < V; y++)
      for (int x = 0; x < H; x++)
        for (int ch = 0; ch < NCH; ch++)
          if (tb_match(ch, pixel(x, y))) begin
            sx[ch] += x; sy[ch] += y; n[ch]++;
          end
    for (int ch = 0; ch < NCH; ch++)
      if (!fz) begin
        if (n[ch] >= MINP) begin
          r.cx[ch*10 +: 10] = 10'(sx[ch] / n[ch]);
          r.cy[ch*9 +: 9]   = 9'(sy[ch] / n[ch]);
          r.v[ch] = 1'b1;
        end else begin
          r.v[ch] = 1'b0;
        end
      end
    return r;
  endfunction

  function automatic logic [23:0] exp_video(int x, int y, logic [23:0] p);
    int cx, cy, dx, dy;
    if (ovl)
      for (int ch = 0; ch < NCH; ch++)
        if (m_state.v[ch]) begin
          cx = int'(m_state.cx[ch*10 +: 10]);
          cy = int'(m_state.cy[ch*9 +: 9]);
          dx = (x > cx) ? x - cx : cx - x;
          dy = (y > cy) ? y - cy : cy - y;
          if ((x == cx && dy <= ML) || (y == cy && dx <= ML)) return 24'h7F7F7F;
        end
    return p;
  endfunction

  task automatic drive_frame(input bit push);
    logic [23:0] p;
    if (push) rq.push_back(predict());
    bus.freeze = fz;
    bus.overlay_en = ovl;
    bus.v_sync = 1'b1; bus.h_sync = 1'b0; bus.active_area = 1'b0; bus.video_in = '0;
    tick(); tick();
    for (int y = 0; y < V; y++) begin
      for (int x = 0; x < H; x++) begin
        p = pixel(x, y);
        vq.push_back(exp_video(x, y, p));
        bus.h_sync = 1'b1; bus.active_area = 1'b1; bus.video_in = p;
        tick();
        check($sformatf("video(%0d,%0d)", x, y), bus.video_out, vq.pop_front());
      end
      bus.h_sync = 1'b0; bus.active_area = 1'b0; bus.video_in = '0;
      repeat (4) tick();
    end
    bus.v_sync = 1'b0;
    tick();
  endtask

  task automatic wait_done(input string tag);
    bit seen = 1'b0;
    res_t r;
    for (int i = 0; i < 1000 && !seen; i++) begin
      if (bus.frame_done === 1'b1) seen = 1'b1;
      else tick();
    end
    check({tag, "_done_seen"}, seen, 1'b1);
    r = (rq.size() > 0) ? rq.pop_front() : m_state;
    check({tag, "_cx"}, bus.centroid_x, r.cx);
    check({tag, "_cy"}, bus.centroid_y, r.cy);
    check({tag, "_valid"}, bus.centroid_valid, r.v);
    m_state = r;
    tick();
    check({tag, "_done_pulse"}, bus.frame_done, 1'b0);
  endtask

  task automatic set_blob(input int x0, input int x1, input int y0, input int y1);
    bx0 = x0; bx1 = x1; by0 = y0; by1 = y1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int pulses;
    rst = 1'b1;
    bus.video_in = '0; bus.h_sync = 1'b0; bus.v_sync = 1'b0; bus.active_area = 1'b0;
    bus.freeze = 1'b0; bus.overlay_en = 1'b0;
    bus.cfg_primary = {2'(prim[1]), 2'(prim[0])};
    bus.cfg_margin  = {8'(marg[1]), 8'(marg[0])};
    fz = 1'b0; ovl = 1'b0; gn = 0; m_state = '0;
    tick(); tick();
    check("rst_video", bus.video_out, 24'h0);
    check("rst_cx", bus.centroid_x, 20'h0);
    check("rst_cy", bus.centroid_y, 18'h0);
    check("rst_valid", bus.centroid_valid, 2'b00);
    check("rst_done", bus.frame_done, 1'b0);
    check("rst_overrun", bus.frame_overrun, 1'b0);
    rst = 1'b0;
    tick();

    // Red blob centred (5,3); green channel sees nothing.
    set_blob(4, 7, 2, 5);
    drive_frame(1); wait_done("f1");
    // Three green pixels: below the minimum, green stays invalid.
    gn = 3;
    drive_frame(1); wait_done("f2");
    gn = 0;
    // Overlay on, markers at (5,3); new blob at the corner.
    ovl = 1'b1;
    set_blob(0, 1, 0, 1);
    drive_frame(1); wait_done("f3");
    // Markers at (0,0): nothing may wrap to the far edge.
    set_blob(4, 7, 2, 5);
    drive_frame(1); wait_done("f4");
    // Frozen: blob moves to (10,6) but outputs hold (5,3).
    fz = 1'b1;
    set_blob(9, 11, 5, 7);
    drive_frame(1); wait_done("f5");
    fz = 1'b0;
    drive_frame(1); wait_done("f6");

    // Reset in the middle of the division.
    set_blob(4, 7, 2, 5);
    drive_frame(0);
    repeat (10) tick();
    rst = 1'b1;
    tick();
    check("mid_rst_video", bus.video_out, 24'h0);
    check("mid_rst_cx", bus.centroid_x, 20'h0);
    check("mid_rst_cy", bus.centroid_y, 18'h0);
    check("mid_rst_valid", bus.centroid_valid, 2'b00);
    check("mid_rst_done", bus.frame_done, 1'b0);
    rst = 1'b0;
    m_state = '0;
    pulses = 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (bus.frame_done === 1'b1) pulses++;
    end
    check("mid_rst_no_done", pulses, 0);
    drive_frame(1); wait_done("f8");

    // Second frame end while dividing: overrun pulse, first result still published.
    set_blob(9, 11, 5, 7);
    drive_frame(1);
    repeat (5) tick();
    bus.v_sync = 1'b1;
    tick(); tick();
    bus.v_sync = 1'b0;
    tick();
    check("overrun_pulse", bus.frame_overrun, 1'b1);
    tick();
    check("overrun_clear", bus.frame_overrun, 1'b0);
    wait_done("f9");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
